rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//   Shares one N-input, W-bit mux datapath among N requesters using round-robin arbitration.
//   Each requester presents data with a valid/ready handshake. The winner's word is captured
//   in a one-entry output register. The block drives the shared mux select and sits upstream
//   of the ALU operand path.
// PARAMETERS
//   N  3                 number of requesters (2..8)
//   W  2                 data width per requester
//   S  $clog2(N)         select / source-index width (derived; do not override)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   req_valid  in   N      requester i has a word on req_data[i*W +: W]
//   req_data   in   N*W    packed requester words; requester 0 in the LSBs
//   req_ready  out  N      one-hot (or zero) accept strobe back to requesters
//   grant_sel  out  S      combinational index of the current winner; drives the shared mux select
//   out_valid  out  1      output register holds a word
//   out_data   out  W      registered winning word
//   out_src    out  S      index of the requester that supplied out_data
//   out_ready  in   1      downstream consumes the output word this cycle
// BEHAVIOUR
//   - Reset (rst=1 at posedge): out_valid=0, out_data=0, out_src=0, last_ptr=N-1.
//     last_ptr=N-1 makes requester 0 the first winner. Reset mid-transfer drops the held word.
//   - Output states: EMPTY (out_valid=0) and FULL (out_valid=1).
//   - accept_en = !out_valid || out_ready. This gives a full-throughput pipeline:
//     the register refills in the same cycle it drains.
//   - Winner: the first i with req_valid[i]=1, searching last_ptr+1, last_ptr+2, ... mod N.
//     - grant_sel = winner index; grant_sel = last_ptr+1 mod N when no request is present.
//   - req_ready[i] = accept_en && req_valid[i] && (i == winner). At most one bit is set.
//   - Transfer when req_valid[i] && req_ready[i]. At the next posedge:
//     - out_data <= req_data[winner]; out_src <= winner; out_valid <= 1; last_ptr <= winner.
//   - No transfer and out_ready=1: out_valid <= 0 (FULL->EMPTY). out_data and out_src keep their values.
//   - FULL and out_ready=0: stall. req_ready is all 0, and out_data, out_src and last_ptr are held.
//   - Latency: 1 cycle from accepted request to out_valid.
//   - Requesters may deassert valid without a grant; no requirement to stay valid.
//   - Wrap-around: when last_ptr=N-1, the search starts at 0.
//   - Sole requester: it wins every accept cycle, with back-to-back transfers.
//   - last_ptr updates only on a transfer, never on stall or idle.
// CONFIGURATION
//   RR_MUX_ARBITER_LOCK_EN
//   - Defined:
//     - Adds port req_lock (in, N).
//     - If the transfer from requester k had req_lock[k]=1, a lock is held on k.
//     - While locked, winner = k if req_valid[k]=1; otherwise no grant is issued and others wait.
//     - The lock clears on the first transfer from k with req_lock[k]=0, or on rst.
//     - Intended for multi-word operands that must not interleave.
//   - Undefined: the req_lock port is absent and arbitration is pure round-robin as above.
// STRUCTURE
//   - Package arb_pkg:
//     - typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t
//     - localparam MAX_N = 8
//     - function automatic rr_next(ptr, n) for modulo increment
//   - Sub-module rr_pick: combinational rotate-priority encoder.
//     - Inputs: req[N], last_ptr[S]. Outputs: winner[S], any.
//   - Data selection: indexed part-select of req_data by winner.
//   - All state is in a single always_ff; output logic is in always_comb.
// TESTING
//   1. Reset with all req_valid=1 -> the first grant goes to req 0; out_src sequence 0,1,2,0,1,2 with out_ready=1.
//   2. req_valid=3'b101, out_ready=1 -> out_src alternates 0,2,0,2; req 1 never gets a req_ready.
//   3. FULL, out_ready=0 for 4 cycles -> req_ready=0, out_data stable; the next grant resumes at last_ptr+1.
//   4. Single req 2 valid, data=2'b11, out_ready=1 -> out_valid=1 every cycle, out_data=3, out_src=2.
//   5. Assert rst while out_valid=1 -> next cycle out_valid=0, out_data=0; the first grant goes to req 0 again.
//   6. LOCK_EN, req1 sends with lock=1,1,0 while req0 and req2 are valid -> out_src 1,1,1 then 2.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin mux arbiter.
package arb_pkg;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
    localparam int MAX_N = 8;
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder; the first request found at last_ptr+1, last_ptr+2, ... mod N wins.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 3,
    parameter int S = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [S-1:0] last_ptr,
    output logic [S-1:0] winner,
    output logic         any
);
    // Scan farthest-first so the nearest requester after last_ptr overwrites the rest.
    always_comb begin
        winner = S'(rr_next(int'(last_ptr), N));
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last_ptr) + k) % N]) begin
                winner = S'((int'(last_ptr) + k) % N);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one N:1 W-bit mux, one-entry output register.
// Optional RR_MUX_ARBITER_LOCK_EN adds req_lock to keep multi-word bursts from interleaving.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 2,
    parameter int S = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic [S-1:0]   grant_sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [S-1:0]   out_src,
    input  logic           out_ready
`ifdef RR_MUX_ARBITER_LOCK_EN
    ,
    input  logic [N-1:0]   req_lock
`endif
);
    out_state_t   state;
    logic [S-1:0] last_ptr;
    logic [S-1:0] winner;
    logic         any;
    logic         accept_en;
    logic         xfer;
    logic [N-1:0] req_eff;

`ifdef RR_MUX_ARBITER_LOCK_EN
    logic         locked;
    logic [S-1:0] lock_idx;
    // A held lock hides every requester except the lock owner.
    assign req_eff = locked ? (req_valid & (N'(1) << lock_idx)) : req_valid;
`else
    assign req_eff = req_valid;
`endif

    rr_pick #(.N(N), .S(S)) u_pick (
        .req      (req_eff),
        .last_ptr (last_ptr),
        .winner   (winner),
        .any      (any)
    );

    always_comb begin
        out_valid = state == OUT_FULL;
        accept_en = !out_valid || out_ready;
        grant_sel = winner;
        req_ready = (accept_en && any) ? (N'(1) << winner) : '0;
        xfer      = |req_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OUT_EMPTY;
            out_data <= '0;
            out_src  <= '0;
            last_ptr <= S'(N - 1);
`ifdef RR_MUX_ARBITER_LOCK_EN
            locked   <= 1'b0;
            lock_idx <= '0;
`endif
        end else if (xfer) begin
            state    <= OUT_FULL;
            out_data <= req_data[int'(winner)*W +: W];
            out_src  <= winner;
            last_ptr <= winner;
`ifdef RR_MUX_ARBITER_LOCK_EN
            locked   <= req_lock[winner];
            lock_idx <= winner;
`endif
        end else if (out_ready) begin
            state <= OUT_EMPTY;
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scoreboard bench with a queue-based round-robin reference model.
module tb_rr_mux_arbiter;
    localparam int N = 3;
    localparam int W = 2;
    localparam int S = $clog2(N);
`ifdef RR_MUX_ARBITER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] d;
        int           src;
    } word_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [S-1:0]   grant_sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_src;
    logic           out_ready = 1'b0;
    logic [N-1:0]   req_lock = '0;

    int checks = 0;
    int failures = 0;
    word_t sb[$];

    int m_last;
    bit m_full;
    bit m_locked;
    int m_lock_k;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_sel (grant_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef RR_MUX_ARBITER_LOCK_EN
        ,
        .req_lock  (req_lock)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: candidates are listed in round-robin order starting after the last winner.
    function automatic int ref_winner(input logic [N-1:0] v);
        int order[$];
        for (int o = 1; o <= N; o++) order.push_back((m_last + o) % N);
        if (LOCK && m_locked) return v[m_lock_k] ? m_lock_k : -1;
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; out_ready = 1'b0; req_lock = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_full = 0; m_last = N - 1; m_locked = 0; m_lock_k = 0;
        sb.delete();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_src", int'(out_src), 0);
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r, input logic [N-1:0] lk);
        int w;
        bit acc;
        word_t e;
        @(posedge clk); #1;
        req_valid = v; req_data = d; out_ready = r; req_lock = lk;
        #1;
        w = ref_winner(v);
        acc = !m_full || r;
        check("req_ready", int'(req_ready), (acc && w >= 0) ? (1 << w) : 0);
        if (w >= 0) check("grant_sel", int'(grant_sel), w);
        else if (!(LOCK && m_locked)) check("grant_sel_idle", int'(grant_sel), (m_last + 1) % N);
        if (acc && w >= 0) begin
            e.d = d[w*W +: W];
            e.src = w;
            sb.push_back(e);
            m_last = w;
            m_full = 1;
            if (LOCK) begin
                m_locked = lk[w];
                m_lock_k = w;
            end
        end else if (r) begin
            m_full = 0;
        end
    endtask

    // Monitor: every consumed word must match the oldest accepted request; stalls must hold the word.
    initial begin
        bit prev_stall = 0;
        logic [W-1:0] prev_d = '0;
        logic [S-1:0] prev_s = '0;
        word_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_data", int'(out_data), int'(prev_d));
                    check("stall_src", int'(out_src), int'(prev_s));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", int'(out_data), int'(e.d));
                        check("out_src", int'(out_src), e.src);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_d = out_data;
                prev_s = out_src;
            end
        end
    end

    initial begin
        do_reset();
        // All requesting: 0,1,2,0,1,2.
        repeat (6) cycle(3'b111, 6'b10_01_00, 1'b1, '0);
        // Requesters 0 and 2 only; 1 never served.
        repeat (6) cycle(3'b101, 6'b11_10_01, 1'b1, '0);
        // Stall four cycles while full, then resume after last winner.
        cycle(3'b111, 6'b01_10_11, 1'b1, '0);
        repeat (4) cycle(3'b111, 6'b01_10_11, 1'b0, '0);
        repeat (3) cycle(3'b111, 6'b01_10_11, 1'b1, '0);
        // Sole requester 2 streams back-to-back.
        repeat (5) cycle(3'b100, 6'b11_00_00, 1'b1, '0);
        cycle(3'b000, '0, 1'b1, '0);
        // Reset while full, then first grant goes to 0 again.
        cycle(3'b010, 6'b00_11_00, 1'b0, '0);
        cycle(3'b000, '0, 1'b0, '0);
        do_reset();
        repeat (3) cycle(3'b111, 6'b11_01_10, 1'b1, '0);
        if (LOCK) begin
            do_reset();
            cycle(3'b111, 6'b11_10_01, 1'b1, 3'b010);
            repeat (2) cycle(3'b111, 6'b11_10_01, 1'b1, 3'b010);
            repeat (3) cycle(3'b111, 6'b11_10_01, 1'b1, 3'b000);
        end
        repeat (400) begin
            cycle(N'($urandom), (N*W)'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
        end
        repeat (4) cycle('0, '0, 1'b1, '0);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
